// File: rtl/filter3x3_pkg.sv
// Shared constants and helpers for the streaming 3x3 filter.
// Kernel arithmetic runs on signed intermediates that are INT_GUARD bits wider than a pixel.
package filter3x3_pkg;

    localparam logic [1:0] MODE_IDENT = 2'd0;
    localparam logic [1:0] MODE_GAUSS = 2'd1;
    localparam logic [1:0] MODE_SHARP = 2'd2;
    localparam logic [1:0] MODE_SOBEL = 2'd3;

    localparam int INT_GUARD = 4;

    function automatic int int_width(input int data_w);
        return data_w + INT_GUARD;
    endfunction

    function automatic int clamp_px(input int v, input int max_v);
        if (v < 0) begin
            return 0;
        end
        if (v > max_v) begin
            return max_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/filter3x3_stream_line_window.sv
// Raster position counters, two line buffers and the 3x3 window (stage 1 of the filter).
// win_o is row-major: [0] = (r-2,c-2), [4] = centre (r-1,c-1), [8] = newest pixel.
module line_window
    import filter3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] win_o [9],
    output logic              win_valid_o,
    output logic              eof_o,
    output logic              sof_o
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]     c_q, c_d;
    logic [RW-1:0]     r_q, r_d;
    logic              win_valid_q;
    logic              eof_q;
    logic              last_col;
    logic              last_row;
    logic              accept;
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] win_q [9];

    assign last_col = (c_q == CW'(IMG_W - 1));
    assign last_row = (r_q == RW'(IMG_H - 1));
    assign accept   = valid_i && !rst;
    assign sof_o    = (c_q == '0) && (r_q == '0);

    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (valid_i) begin
            if (last_col) begin
                c_d = '0;
                r_d = last_row ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q         <= '0;
            r_q         <= '0;
            win_valid_q <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            c_q         <= c_d;
            r_q         <= r_d;
            win_valid_q <= valid_i && (r_q >= RW'(2)) && (c_q >= CW'(2));
            eof_q       <= valid_i && last_row && last_col;
        end
    end

    // lb0 holds row r-1 and lb1 row r-2 at column c; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[c_q] <= lb0_q[c_q];
            lb0_q[c_q] <= pix_i;
            win_q[0]   <= win_q[1];
            win_q[1]   <= win_q[2];
            win_q[2]   <= lb1_q[c_q];
            win_q[3]   <= win_q[4];
            win_q[4]   <= win_q[5];
            win_q[5]   <= lb0_q[c_q];
            win_q[6]   <= win_q[7];
            win_q[7]   <= win_q[8];
            win_q[8]   <= pix_i;
        end
    end

    assign win_o       = win_q;
    assign win_valid_o = win_valid_q;
    assign eof_o       = eof_q;

endmodule

// File: rtl/filter3x3_stream.sv
// Streaming 3x3 filter: per-frame kernel select, kernel sums (stage 2), clamp into output (stage 3).
// Every input pixel is accepted when valid_i is high; there is no backpressure on either side.
module filter3x3_stream
    import filter3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_done_o
);

    localparam int IW      = int_width(DATA_W);
    localparam int PIX_MAX = (1 << DATA_W) - 1;

    logic [DATA_W-1:0]    win [9];
    logic                 win_valid;
    logic                 win_eof;
    logic                 sof;

    logic [1:0]           mode_q;
    logic signed [IW-1:0] e [9];
    logic signed [IW-1:0] gx, gy, ax, ay, gsum, sharp, raw_d;
    logic signed [IW-1:0] raw_q;
    logic [1:0]           mode_s2_q;
    logic                 valid_s2_q;
    logic                 eof_s2_q;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 valid_q;
    logic                 done_q;

    line_window #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_line_window (
        .clk        (clk),
        .rst        (rst),
        .pix_i      (data_i),
        .valid_i    (valid_i),
        .win_o      (win),
        .win_valid_o(win_valid),
        .eof_o      (win_eof),
        .sof_o      (sof)
    );

    // Latched on the frame's first pixel; stage 2 still sees the old mode for the previous frame's tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_IDENT;
        end else if (valid_i && sof) begin
            mode_q <= mode_i;
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            e[i] = $signed({{INT_GUARD{1'b0}}, win[i]});
        end
        gx    = (e[2] + (e[5] <<< 1) + e[8]) - (e[0] + (e[3] <<< 1) + e[6]);
        gy    = (e[6] + (e[7] <<< 1) + e[8]) - (e[0] + (e[1] <<< 1) + e[2]);
        ax    = gx[IW-1] ? -gx : gx;
        ay    = gy[IW-1] ? -gy : gy;
        // Gaussian sum is never negative and peaks at 16*max, which fits the width read as unsigned.
        gsum  = e[0] + (e[1] <<< 1) + e[2] + (e[3] <<< 1) + (e[4] <<< 2)
              + (e[5] <<< 1) + e[6] + (e[7] <<< 1) + e[8];
        sharp = (e[4] <<< 2) + e[4] - e[1] - e[3] - e[5] - e[7];
        case (mode_q)
            MODE_IDENT: raw_d = e[4];
            MODE_GAUSS: raw_d = gsum;
            MODE_SHARP: raw_d = sharp;
            default:    raw_d = ax + ay;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s2_q <= 1'b0;
            eof_s2_q   <= 1'b0;
            mode_s2_q  <= MODE_IDENT;
            raw_q      <= '0;
        end else begin
            valid_s2_q <= win_valid;
            eof_s2_q   <= win_valid && win_eof;
            mode_s2_q  <= mode_q;
            raw_q      <= raw_d;
        end
    end

    always_comb begin
        data_d = data_q;
        if (valid_s2_q) begin
            case (mode_s2_q)
                MODE_IDENT: data_d = raw_q[DATA_W-1:0];
                MODE_GAUSS: data_d = raw_q[IW-1:INT_GUARD];
                default:    data_d = DATA_W'(clamp_px(int'(raw_q), PIX_MAX));
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_s2_q;
            done_q  <= eof_s2_q;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_filter3x3_stream.sv
// Bench for filter3x3_stream on an 8x6 frame: directed images plus random frames, gaps and modes,
// checked every cycle against a per-frame image model with expected values and arrival cycles.
module tb_filter3x3_stream;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int N_OUT  = (IMG_W - 2) * (IMG_H - 2);

  // clock / reset
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data_i = '0;
  logic              valid_i = 1'b0;
  logic [1:0]        mode_i = 2'd0;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              frame_done_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  filter3x3_stream #(
    .DATA_W(DATA_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .mode_i      (mode_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_done_o(frame_done_o)
  );

  // model state and scoreboard
  int                img[IMG_H][IMG_W];
  int                fr_mode = 0;
  logic [DATA_W-1:0] exp_q[$];
  bit                exp_done_q[$];
  int                exp_cyc_q[$];
  logic [DATA_W-1:0] act_log[$];
  logic [DATA_W-1:0] last_exp = '0;
  int                checks = 0;
  int                errors = 0;
  int                fd_count = 0;
  bit                mon_en = 1'b0;
  bit                log_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void fill_image(input int pattern);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        case (pattern)
          0: img[r][c] = 8 * r + c;
          1: img[r][c] = 100;
          2: img[r][c] = (c >= 4) ? 200 : 0;
          3: img[r][c] = (r == 2 && c == 2) ? 255 : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
      end
    end
  endfunction

  // Filter value for the window centred on (cr, cc) of the current image.
  function automatic int model_px(input int mode, input int cr, input int cc);
    int p[9];
    int v, gx, gy;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        p[3 * i + j] = img[cr - 1 + i][cc - 1 + j];
      end
    end
    case (mode)
      0: v = p[4];
      1: v = (p[0] + 2 * p[1] + p[2] + 2 * p[3] + 4 * p[4] + 2 * p[5] + p[6] + 2 * p[7] + p[8]) / 16;
      2: begin
        v = 5 * p[4] - p[1] - p[3] - p[5] - p[7];
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end
      default: begin
        gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
        gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        v = gx + gy;
        if (v > 255) v = 255;
      end
    endcase
    return v;
  endfunction

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  task automatic send_frame(input int pattern, input int mode_start, input int switch_idx,
                            input int mode_after, input int gap_pct, input int abort_idx);
    int r, c;
    fill_image(pattern);
    for (int idx = 0; idx < IMG_W * IMG_H; idx++) begin
      r = idx / IMG_W;
      c = idx % IMG_W;
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        @(negedge clk);
        valid_i = 1'b0;
      end
      @(negedge clk);
      data_i  = DATA_W'(img[r][c]);
      valid_i = 1'b1;
      mode_i  = (switch_idx >= 0 && idx >= switch_idx) ? 2'(mode_after) : 2'(mode_start);
      if (idx == abort_idx) begin
        rst = 1'b1;
        exp_q.delete();
        exp_done_q.delete();
        exp_cyc_q.delete();
        last_exp = '0;
        @(negedge clk);
        rst     = 1'b0;
        valid_i = 1'b0;
        return;
      end
      if (idx == 0) fr_mode = int'(mode_i);
      if (r >= 2 && c >= 2) begin
        exp_q.push_back(DATA_W'(model_px(fr_mode, r - 1, c - 1)));
        exp_done_q.push_back(r == IMG_H - 1 && c == IMG_W - 1);
        exp_cyc_q.push_back(cyc + 3);
      end
    end
  endtask

  task automatic check_ramp_log(input string name);
    check({name, "_count"}, act_log.size(), N_OUT);
    for (int i = 0; i < N_OUT; i++) begin
      if (i < act_log.size()) check({name, "_px"}, int'(act_log[i]), 8 * (i / 6 + 1) + (i % 6 + 1));
    end
    check({name, "_frame_done_count"}, fd_count, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // compare process: every cycle, 1 time unit after the rising edge
  initial begin
    logic [DATA_W-1:0] e;
    bit d;
    int ec;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (valid_o) begin
          if (log_en) act_log.push_back(data_o);
          if (log_en && frame_done_o) fd_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e  = exp_q.pop_front();
            d  = exp_done_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("data", int'(data_o), int'(e));
            check("frame_done", int'(frame_done_o), int'(d));
            check("latency_cycle", cyc, ec);
            last_exp = e;
          end
        end else begin
          check("idle_frame_done", int'(frame_done_o), 0);
          check("hold_data", int'(data_o), int'(last_exp));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_o", int'(valid_o), 0);
    check("reset_data_o", int'(data_o), 0);
    check("reset_frame_done_o", int'(frame_done_o), 0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // identity ramp, back to back
    act_log.delete();
    fd_count = 0;
    log_en   = 1'b1;
    send_frame(0, 0, -1, 0, 0, -1);
    idle(6);
    log_en = 1'b0;
    check_ramp_log("ramp");

    // constant frame in every mode, frames back to back
    fill_image(1);
    check("pin_const_gauss", model_px(1, 2, 2), 100);
    check("pin_const_sharp", model_px(2, 3, 4), 100);
    check("pin_const_sobel", model_px(3, 2, 5), 0);
    for (int m = 0; m < 4; m++) send_frame(1, m, -1, 0, 0, -1);
    idle(5);

    // Sobel vertical edge
    fill_image(2);
    check("pin_sobel_c3", model_px(3, 2, 3), 255);
    check("pin_sobel_c4", model_px(3, 4, 4), 255);
    check("pin_sobel_c2", model_px(3, 2, 2), 0);
    check("pin_sobel_c5", model_px(3, 3, 5), 0);
    send_frame(2, 3, -1, 0, 0, -1);

    // sharpen impulse
    fill_image(3);
    check("pin_sharp_centre", model_px(2, 2, 2), 255);
    check("pin_sharp_up", model_px(2, 1, 2), 0);
    check("pin_sharp_right", model_px(2, 2, 3), 0);
    check("pin_sharp_diag", model_px(2, 3, 3), 0);
    send_frame(3, 2, -1, 0, 0, -1);
    idle(5);

    // ramp with ~50% gaps must give the same sequence
    act_log.delete();
    fd_count = 0;
    log_en   = 1'b1;
    send_frame(0, 0, -1, 0, 50, -1);
    idle(6);
    log_en = 1'b0;
    check_ramp_log("ramp_gaps");

    // mode switched to Sobel at (3,3): rest of frame stays identity, next frame is Sobel
    send_frame(4, 0, 3 * IMG_W + 3, 3, 50, -1);
    send_frame(4, 3, -1, 3, 50, -1);
    idle(5);

    // reset mid-frame at (3,5), then a clean ramp frame
    send_frame(0, 0, -1, 0, 0, 3 * IMG_W + 5);
    idle(4);
    act_log.delete();
    fd_count = 0;
    log_en   = 1'b1;
    send_frame(0, 0, -1, 0, 0, -1);
    idle(6);
    log_en = 1'b0;
    check_ramp_log("ramp_after_reset");

    // random frames, random modes, random gap density
    for (int k = 0; k < 6; k++) begin
      send_frame(4, int'($urandom_range(0, 3)), -1, 0, int'($urandom_range(0, 60)), -1);
    end
    idle(5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
